txt_crt_addr_gen: RTL

TXT_CRT_ADDR_GEN -- requirements
Module: txt_crt_addr_gen

---
 rtl/txt_crt_pkg.sv | 34 +++
 rtl/txt_crt_addr_gen_if.sv | 37 +++
 rtl/txt_font_addr.sv | 24 ++
 rtl/txt_crt_addr_gen.sv | 125 ++++++++++++
 4 files changed

// File: rtl/txt_crt_pkg.sv
// -----------------------------------------------------------------------------
// txt_crt_pkg
// Shared definitions for the text-mode CRT address generator:
//   - address width (16), scanline counter width (5), dummy-read group size (8)
//   - font plane encoding
//   - font_base(): font table base address for a 3-bit character map select
//     (bits [1:0] pick a 16 KiW quarter, bit 2 picks the upper 8 KiW half).
// -----------------------------------------------------------------------------
package txt_crt_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned SCAN_W     = 5;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned MAP_W      = 3;
  localparam int unsigned GROUP_SIZE = 8;
  localparam int unsigned DUM_W      = $clog2(GROUP_SIZE);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SCAN_W-1:0] scan_t;
  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [MAP_W-1:0]  map_t;
  typedef logic [DUM_W-1:0]  dum_t;

  typedef enum logic [1:0] {
    PLANE_FONT_LO = 2'd2,
    PLANE_FONT_HI = 2'd3
  } font_plane_e;

  // map[1:0] * 16'h4000 + map[2] * 16'h2000, written as a bit placement.
  function automatic addr_t font_base(input map_t map);
    return {map[1:0], map[2], {(ADDR_W-3){1'b0}}};
  endfunction

endpackage

// File: rtl/txt_crt_addr_gen_if.sv
// -----------------------------------------------------------------------------
// txt_crt_addr_gen_if
// Bus between the text state machine / character FIFO (master) and the CRT
// address generator (slave).
//   master -> slave : tx_cnt_inc, enrd_tx_addr, enrd_font_addr,
//                     extend_font_addr, dum_ff_read, ff_char, ff_attr3
//   slave -> master : crt_addr, crt_font, font_plane, dum_ff_rd_cnt0
// -----------------------------------------------------------------------------
interface txt_crt_addr_gen_if;
  import txt_crt_pkg::*;

  logic        tx_cnt_inc;
  logic        enrd_tx_addr;
  logic        enrd_font_addr;
  logic        extend_font_addr;
  logic        dum_ff_read;
  char_t       ff_char;
  logic        ff_attr3;

  addr_t       crt_addr;
  logic        crt_font;
  logic [1:0]  font_plane;
  logic        dum_ff_rd_cnt0;

  modport master (
    output tx_cnt_inc, enrd_tx_addr, enrd_font_addr, extend_font_addr,
           dum_ff_read, ff_char, ff_attr3,
    input  crt_addr, crt_font, font_plane, dum_ff_rd_cnt0
  );

  modport slave (
    input  tx_cnt_inc, enrd_tx_addr, enrd_font_addr, extend_font_addr,
           dum_ff_read, ff_char, ff_attr3,
    output crt_addr, crt_font, font_plane, dum_ff_rd_cnt0
  );

endinterface

// File: rtl/txt_font_addr.sv
// -----------------------------------------------------------------------------
// txt_font_addr
// Combinational font glyph address: font_base(c_map) + char_code*32 + scan.
// Each glyph occupies 32 consecutive words, one per scanline. 16-bit wrap.
// Ports:
//   c_map     in  3   character map select
//   char_code in  8   character code
//   scan      in  5   scanline within the character cell
//   font_addr out 16  memory word address of the glyph row
// -----------------------------------------------------------------------------
module txt_font_addr
  import txt_crt_pkg::*;
(
  input  map_t  c_map,
  input  char_t char_code,
  input  scan_t scan,
  output addr_t font_addr
);

  assign font_addr = font_base(c_map)
                   + {{(ADDR_W-CHAR_W-5){1'b0}}, char_code, 5'b0}
                   + {{(ADDR_W-SCAN_W){1'b0}}, scan};

endmodule

// File: rtl/txt_crt_addr_gen.sv
// -----------------------------------------------------------------------------
// txt_crt_addr_gen
// Text-mode CRT memory address generator. Tracks the row start address, the
// running character address and the scanline within the character row, and
// issues either text (character/attribute) or font glyph fetch addresses on
// request from the text state machine. Also counts dummy FIFO reads in groups
// of eight.
//
// Ports:
//   mem_clk                 in   memory clock, all state on rising edge
//   hreset                  in   synchronous active-high reset
//   sync_c_crt_frame_start  in   pulse, start of vertical display
//   sync_c_crt_line_end     in   pulse, end of scanline
//   c_start_addr, c_offset, c_max_scan, c_preset_scan,
//   c_map_a, c_map_b, c_paged_font   quasi-static CRTC/sequencer registers
//   bus (slave)             strobes/FIFO head in, crt_addr/crt_font/
//                           font_plane/dum_ff_rd_cnt0 out
//
// Build option: define TXT_CRT_CHAR512_EN for 512-character fonts, where
// attribute bit 3 selects between c_map_a and c_map_b. Without it c_map_b is
// always used and ff_attr3 is ignored.
// -----------------------------------------------------------------------------
module txt_crt_addr_gen
  import txt_crt_pkg::*;
(
  input  logic               mem_clk,
  input  logic               hreset,
  input  logic               sync_c_crt_frame_start,
  input  logic               sync_c_crt_line_end,
  input  addr_t              c_start_addr,
  input  logic [7:0]         c_offset,
  input  scan_t              c_max_scan,
  input  scan_t              c_preset_scan,
  input  map_t               c_map_a,
  input  map_t               c_map_b,
  input  logic               c_paged_font,
  txt_crt_addr_gen_if.slave  bus
);

  addr_t row_addr;
  addr_t char_addr;
  scan_t scan;
  dum_t  dum_cnt;

  addr_t next_row_addr;
  addr_t font_addr;
  map_t  c_map;
  logic  sync_cycle;

  // Frame start and line end take the cycle; all text-SM strobes are dropped.
  assign sync_cycle = sync_c_crt_frame_start | sync_c_crt_line_end;

  // Row pitch is programmed in units of two words.
  assign next_row_addr = row_addr + {{(ADDR_W-9){1'b0}}, c_offset, 1'b0};

`ifdef TXT_CRT_CHAR512_EN
  assign c_map = bus.ff_attr3 ? c_map_a : c_map_b;
`else
  logic [MAP_W:0] char512_unused;
  assign c_map          = c_map_b;
  assign char512_unused = {bus.ff_attr3, c_map_a};
`endif

  txt_font_addr u_font_addr (
    .c_map     (c_map),
    .char_code (bus.ff_char),
    .scan      (scan),
    .font_addr (font_addr)
  );

  // Address tracking state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge mem_clk) begin
    if (hreset) begin
      row_addr  <= '0;
      char_addr <= '0;
      scan      <= '0;
      dum_cnt   <= '0;
    end else if (sync_c_crt_frame_start) begin
      row_addr  <= c_start_addr;
      char_addr <= c_start_addr;
      scan      <= c_preset_scan;
      dum_cnt   <= '0;
    end else if (sync_c_crt_line_end) begin
      if (scan == c_max_scan) begin
        scan      <= '0;
        row_addr  <= next_row_addr;
        char_addr <= next_row_addr;
      end else begin
        scan      <= scan + SCAN_W'(1);
        char_addr <= row_addr;
      end
      dum_cnt <= '0;
    end else begin
      if (bus.tx_cnt_inc) char_addr <= char_addr + ADDR_W'(1);
      if (bus.dum_ff_read) dum_cnt  <= dum_cnt + DUM_W'(1);
    end
  end

  // Fetch address register. Font wins over text if both are requested.
  // crt_addr holds between requests; crt_font drops once no fetch or
  // extension is active.
  always_ff @(posedge mem_clk) begin
    if (hreset) begin
      bus.crt_addr   <= '0;
      bus.crt_font   <= 1'b0;
      bus.font_plane <= PLANE_FONT_LO;
    end else if (sync_cycle) begin
      bus.crt_font <= 1'b0;
    end else if (bus.enrd_font_addr) begin
      bus.crt_addr   <= font_addr;
      bus.crt_font   <= 1'b1;
      bus.font_plane <= c_paged_font ? PLANE_FONT_HI : PLANE_FONT_LO;
    end else if (bus.enrd_tx_addr) begin
      bus.crt_addr <= char_addr;
      bus.crt_font <= 1'b0;
    end else if (!bus.extend_font_addr) begin
      bus.crt_font <= 1'b0;
    end
  end

  assign bus.dum_ff_rd_cnt0 = (dum_cnt == DUM_W'(GROUP_SIZE-1));

endmodule
